// File: rtl/bsg_manycore_pkg.sv
// Shared manycore constants and helpers used by the DPI request path.
package bsg_manycore_pkg;

    localparam int bsg_manycore_aligned_fifo_width_gp = 128;

    // Width of a counter that must hold 0..max_credits inclusive.
    function automatic int bsg_manycore_credit_width(input int max_credits);
        return $clog2(max_credits + 1);
    endfunction

endpackage

// File: rtl/bsg_manycore_dpi_req_ring.sv
// Register-array ring buffer with head/tail/count; caller guarantees no enq when full
// and no deq when empty.
module bsg_manycore_dpi_req_ring
    import bsg_manycore_pkg::*;
#(
    parameter  int width_p        = bsg_manycore_aligned_fifo_width_gp,
    parameter  int els_p          = 4,
    localparam int ptr_width_lp   = $clog2(els_p),
    localparam int count_width_lp = $clog2(els_p + 1)
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      enq_i,
    input  logic [width_p-1:0]        data_i,
    input  logic                      deq_i,
    output logic [width_p-1:0]        data_o,
    output logic [count_width_lp-1:0] count_o,
    output logic                      full_o,
    output logic                      empty_o
);

    logic [width_p-1:0]        mem_q [els_p];
    logic [ptr_width_lp-1:0]   head_q, head_d;
    logic [ptr_width_lp-1:0]   tail_q, tail_d;
    logic [count_width_lp-1:0] count_q, count_d;

    assign full_o  = (count_q == count_width_lp'(els_p));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = empty_o ? '0 : mem_q[head_q];

    // Pointers roll over naturally because els_p is a power of two.
    always_comb begin
        head_d  = head_q;
        tail_d  = tail_q;
        count_d = count_q;
        if (enq_i) tail_d = tail_q + 1'b1;
        if (deq_i) head_d = head_q + 1'b1;
        case ({enq_i, deq_i})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is deliberately left out of reset; empty_o masks stale contents.
    always_ff @(posedge clk_i) begin
        if (enq_i) mem_q[tail_q] <= data_i;
    end

endmodule

// File: rtl/bsg_manycore_dpi_req_credit_buffer.sv
// Buffers DPI tile request packets and releases them to the endpoint only while
// out-credits remain, accounting for the one-cycle lag of the endpoint credit counter.
module bsg_manycore_dpi_req_credit_buffer
    import bsg_manycore_pkg::*;
#(
    parameter  int fifo_width_p            = bsg_manycore_aligned_fifo_width_gp,
    parameter  int els_p                   = 4,
    parameter  int max_out_credits_p       = 32,
    localparam int credit_counter_width_lp = bsg_manycore_credit_width(max_out_credits_p),
    localparam int count_width_lp          = $clog2(els_p + 1)
) (
    input  logic                               clk_i,
    input  logic                               reset_i,
    input  logic                               enq_v_i,
    input  logic [fifo_width_p-1:0]            enq_data_i,
    output logic                               enq_ready_o,
    output logic                               req_v_o,
    output logic [fifo_width_p-1:0]            req_data_o,
    input  logic                               req_ready_i,
    input  logic [credit_counter_width_lp-1:0] out_credits_i,
    output logic [count_width_lp-1:0]          count_o,
    output logic [31:0]                        sent_o,
    output logic [31:0]                        stall_o
);

    logic                               full, empty;
    logic                               enq_fire, deq_fire, stall_cond;
    logic                               inflight_q;
    logic [credit_counter_width_lp-1:0] inflight_ext;
    logic [credit_counter_width_lp-1:0] eff_credits;
    logic [31:0]                        sent_q, stall_q;

    bsg_manycore_dpi_req_ring #(
        .width_p (fifo_width_p),
        .els_p   (els_p)
    ) ring (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .enq_i   (enq_fire),
        .data_i  (enq_data_i),
        .deq_i   (deq_fire),
        .data_o  (req_data_o),
        .count_o (count_o),
        .full_o  (full),
        .empty_o (empty)
    );

    // A send from last cycle has not yet been subtracted by the endpoint.
    assign inflight_ext = credit_counter_width_lp'(inflight_q);
    assign eff_credits  = (out_credits_i > inflight_ext) ? (out_credits_i - inflight_ext) : '0;

    assign enq_ready_o = !full;
    assign enq_fire    = enq_v_i & enq_ready_o;
    assign req_v_o     = !empty && (eff_credits != '0);
    assign deq_fire    = req_v_o & req_ready_i;
    assign stall_cond  = !empty && (eff_credits == '0);

    assign sent_o  = sent_q;
    assign stall_o = stall_q;

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            inflight_q <= 1'b0;
            sent_q     <= '0;
            stall_q    <= '0;
        end else begin
            inflight_q <= deq_fire;
            if (deq_fire && (sent_q != '1))    sent_q  <= sent_q + 1'b1;
            if (stall_cond && (stall_q != '1)) stall_q <= stall_q + 1'b1;
        end
    end

    a_enq_honours_ready: assert property (@(posedge clk_i) disable iff (!reset_i)
        !(enq_v_i && !enq_ready_o));
    a_count_bounded: assert property (@(posedge clk_i) disable iff (!reset_i)
        count_o <= count_width_lp'(els_p));

endmodule
